dtu_stream_decoder: RTL



---
 rtl/dtu_stream_pkg.sv | 61 ++++++
 rtl/dtu_sample_unpacker.sv | 92 +++++++++
 rtl/dtu_stream_decoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dtu_stream_pkg.sv
// Shared word-type encoding, header constants and classification helpers
// for the LiTe-DTU serial stream decoder.
package dtu_stream_pkg;

    typedef enum logic [3:0] {
        WT_IDLE    = 4'd0,
        WT_BASE5   = 4'd1,
        WT_BASEN   = 4'd2,
        WT_SIG2    = 4'd3,
        WT_SIG1    = 4'd4,
        WT_HEADER  = 4'd5,
        WT_RESET   = 4'd6,
        WT_TRAILER = 4'd7,
        WT_ERROR   = 4'd8,
        WT_RAW     = 4'd9
    } word_type_e;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } dec_state_e;

    localparam logic [1:0] HDR_BASE5   = 2'b01;
    localparam logic [1:0] HDR_BASEN   = 2'b10;
    localparam logic [5:0] HDR_SIG2    = 6'b001010;
    localparam logic [6:0] HDR_SIG1    = 7'b0010110;
    localparam logic [6:0] HDR_HEADER  = 7'b0010111;
    localparam logic [3:0] HDR_IDLE    = 4'b1110;
    localparam logic [5:0] HDR_RESET   = 6'b001101;
    localparam logic [3:0] HDR_TRAILER = 4'b1101;

    // hdr is the top byte of the lane-0 word; checks run in priority order.
    function automatic word_type_e classify_word(input logic [7:0] hdr, input logic raw);
        word_type_e t;
        if (raw)                           t = WT_RAW;
        else if (hdr[7:6] == HDR_BASE5)    t = WT_BASE5;
        else if (hdr[7:6] == HDR_BASEN)
            t = (hdr[2:0] >= 3'd1 && hdr[2:0] <= 3'd4) ? WT_BASEN : WT_ERROR;
        else if (hdr[7:2] == HDR_SIG2)     t = WT_SIG2;
        else if (hdr[7:1] == HDR_SIG1)     t = WT_SIG1;
        else if (hdr[7:1] == HDR_HEADER)   t = WT_HEADER;
        else if (hdr[7:4] == HDR_IDLE)     t = WT_IDLE;
        else if (hdr[7:2] == HDR_RESET)    t = WT_RESET;
        else if (hdr[7:4] == HDR_TRAILER)  t = WT_TRAILER;
        else                               t = WT_ERROR;
        return t;
    endfunction

    function automatic logic [2:0] sample_count(input word_type_e t, input logic [2:0] basen_cnt);
        logic [2:0] n;
        case (t)
            WT_BASE5:             n = 3'd5;
            WT_BASEN:             n = basen_cnt;
            WT_SIG2:              n = 3'd2;
            WT_SIG1, WT_HEADER:   n = 3'd1;
            default:              n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dtu_sample_unpacker.sv
// Emits the samples of a classified word one per clock, lowest field first,
// starting the cycle after load_i.
module dtu_sample_unpacker (
    input  logic        clk_srl,
    input  logic        rst,
    input  logic        load_i,
    input  logic [29:0] word_i,
    input  logic [3:0]  type_i,
    output logic        sample_valid,
    output logic        sample_gain,
    output logic [11:0] sample_data,
    output logic        sample_is_base
);
    import dtu_stream_pkg::*;

    logic [29:0] word_q;
    logic        base_q;
    logic [2:0]  cnt_q;
    logic [2:0]  fidx_q;

    logic        valid_q, gain_q, is_base_q;
    logic [11:0] data_q;

    logic [29:0] src_word;
    logic        src_base;
    logic [2:0]  src_cnt;
    logic [2:0]  src_idx;
    logic        emit;
    logic        field_gain;
    logic [11:0] field_data;
    logic        load_base;
    logic [2:0]  load_cnt;

    assign load_base = (type_i == WT_BASE5) || (type_i == WT_BASEN);
    assign load_cnt  = sample_count(word_type_e'(type_i), word_i[26:24]);

    // A fresh word bypasses the holding registers so its first sample is not delayed.
    always_comb begin
        src_word   = load_i ? word_i    : word_q;
        src_base   = load_i ? load_base : base_q;
        src_cnt    = load_i ? load_cnt  : cnt_q;
        src_idx    = load_i ? 3'd0      : fidx_q;
        emit       = (src_idx < src_cnt);
        field_gain = 1'b0;
        field_data = '0;
        if (src_base) begin
            case (src_idx)
                3'd0:    field_data = {6'd0, src_word[5:0]};
                3'd1:    field_data = {6'd0, src_word[11:6]};
                3'd2:    field_data = {6'd0, src_word[17:12]};
                3'd3:    field_data = {6'd0, src_word[23:18]};
                default: field_data = {6'd0, src_word[29:24]};
            endcase
        end else if (src_idx == 3'd0) begin
            field_gain = src_word[12];
            field_data = src_word[11:0];
        end else begin
            field_gain = src_word[25];
            field_data = src_word[24:13];
        end
    end

    always_ff @(posedge clk_srl) begin
        if (rst) begin
            word_q    <= '0;
            base_q    <= 1'b0;
            cnt_q     <= '0;
            fidx_q    <= '0;
            valid_q   <= 1'b0;
            gain_q    <= 1'b0;
            data_q    <= '0;
            is_base_q <= 1'b0;
        end else begin
            if (load_i) begin
                word_q <= word_i;
                base_q <= load_base;
                cnt_q  <= load_cnt;
            end
            fidx_q    <= emit ? src_idx + 3'd1 : src_idx;
            valid_q   <= emit;
            gain_q    <= emit ? field_gain : 1'b0;
            data_q    <= emit ? field_data : 12'd0;
            is_base_q <= emit ? src_base : 1'b0;
        end
    end

    assign sample_valid   = valid_q;
    assign sample_gain    = gain_q;
    assign sample_data    = data_q;
    assign sample_is_base = is_base_q;

endmodule

// File: rtl/dtu_stream_decoder.sv
// LiTe-DTU serial receiver: hunts for the idle sync byte on lane 0, deserialises
// all lanes into words, classifies lane-0 words and keeps frame/error counters.
module dtu_stream_decoder #(
    parameter int         NUM_LANES = 4,
    parameter int         WORD_W    = 32,
    parameter logic [7:0] IDLE_DTU  = 8'b00110101,
    parameter logic [7:0] IDLE_ATM  = 8'b01011010,
    parameter int         LOCK_MISS = 4,
    parameter int         CNT_W     = 16
) (
    input  logic                        clk_srl,
    input  logic                        rst,
    input  logic [NUM_LANES-1:0]        ser_in,
    input  logic                        test_enable,
    input  logic                        calibration_busy,
    output logic                        locked,
    output logic                        word_valid,
    output logic [NUM_LANES*WORD_W-1:0] word_data,
    output logic [3:0]                  word_type,
    output logic                        sample_valid,
    output logic                        sample_gain,
    output logic [11:0]                 sample_data,
    output logic                        sample_is_base,
    output logic [CNT_W-1:0]            frame_count,
    output logic [CNT_W-1:0]            error_count
);
    import dtu_stream_pkg::*;

    localparam int IDX_W  = $clog2(WORD_W);
    localparam int MISS_W = $clog2(LOCK_MISS + 1);

    dec_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [MISS_W-1:0]  miss_q;
    logic               word_valid_q;
    word_type_e         word_type_q;
    logic [CNT_W-1:0]   frame_q, error_q;

    logic [6:0]         sr_lane0;
    logic [WORD_W-1:1]  word_lane0;
    logic [7:0]         sync_byte;
    logic               hunt_match, word_done, miss_hit;
    word_type_e         done_type;

    assign sync_byte  = test_enable ? IDLE_ATM : IDLE_DTU;
    assign hunt_match = (state_q == ST_HUNT) && ({sr_lane0, ser_in[0]} == sync_byte);
    assign word_done  = (state_q == ST_LOCKED) && (idx_q == '0);
    assign done_type  = classify_word(word_lane0[WORD_W-1 -: 8], test_enable | calibration_busy);
    assign miss_hit   = word_done && (done_type == WT_ERROR) && (miss_q == MISS_W'(LOCK_MISS - 1));

    // The sync byte becomes the top byte of the first word on every lane.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [6:0]        sr_q;
        logic [WORD_W-1:1] word_q;
        logic [WORD_W-1:0] out_q;

        always_ff @(posedge clk_srl) begin
            if (rst) begin
                sr_q   <= '0;
                word_q <= '0;
                out_q  <= '0;
            end else if (state_q == ST_HUNT) begin
                sr_q <= {sr_q[5:0], ser_in[gi]};
                if (hunt_match)
                    word_q[WORD_W-1 -: 8] <= {sr_q, ser_in[gi]};
            end else begin
                if (idx_q != '0)
                    word_q[idx_q] <= ser_in[gi];
                else
                    out_q <= {word_q, ser_in[gi]};
                if (miss_hit)
                    sr_q <= '0;
            end
        end

        assign word_data[gi*WORD_W +: WORD_W] = out_q;

        if (gi == 0) begin : g_tap
            assign sr_lane0   = sr_q;
            assign word_lane0 = word_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:   if (hunt_match) state_d = ST_LOCKED;
            ST_LOCKED: if (miss_hit)   state_d = ST_HUNT;
            default:   state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_srl) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            idx_q        <= '0;
            miss_q       <= '0;
            word_valid_q <= 1'b0;
            word_type_q  <= WT_IDLE;
            frame_q      <= '0;
            error_q      <= '0;
        end else begin
            state_q      <= state_d;
            word_valid_q <= word_done;
            if (hunt_match)
                idx_q <= IDX_W'(WORD_W - 9);
            else if (state_q == ST_LOCKED)
                idx_q <= (idx_q == '0) ? IDX_W'(WORD_W - 1) : idx_q - 1'b1;
            if (word_done) begin
                word_type_q <= done_type;
                if (done_type == WT_ERROR) begin
                    miss_q <= miss_hit ? '0 : miss_q + 1'b1;
                    if (error_q != '1) error_q <= error_q + 1'b1;
                end else begin
                    miss_q <= '0;
                end
                if (done_type == WT_TRAILER && frame_q != '1)
                    frame_q <= frame_q + 1'b1;
            end
        end
    end

    dtu_sample_unpacker u_unpacker (
        .clk_srl        (clk_srl),
        .rst            (rst),
        .load_i         (word_valid_q),
        .word_i         (word_data[29:0]),
        .type_i         (word_type_q),
        .sample_valid   (sample_valid),
        .sample_gain    (sample_gain),
        .sample_data    (sample_data),
        .sample_is_base (sample_is_base)
    );

    assign locked      = (state_q == ST_LOCKED);
    assign word_valid  = word_valid_q;
    assign word_type   = word_type_q;
    assign frame_count = frame_q;
    assign error_count = error_q;

endmodule
